// File: rtl/load_scoreboard.sv
// Register scoreboard that tracks long-latency destination registers from issue to writeback.
// Latency: issue is visible in pending_vec after 1 cycle; a writeback releases a stall in the same cycle (bypass).
// Backpressure: issue_stall holds issue on a pending source, a full in-flight table, or a saturated rd counter.
module load_scoreboard #(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              issue_valid,
    input  logic [4:0]                        issue_rs1_addr,
    input  logic [4:0]                        issue_rs2_addr,
    input  logic                              issue_uses_rs1,
    input  logic                              issue_uses_rs2,
    input  logic                              issue_writes_rd,
    input  logic [4:0]                        issue_rd_addr,
    output logic                              issue_stall,
    input  logic                              wb_valid,
    input  logic [4:0]                        wb_rd_addr,
    output logic [31:0]                       pending_vec,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_count,
    output logic                              full,
    output logic                              wb_err
);

    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [IW-1:0]    MAX_IF  = IW'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt [32];

    logic        wb_nz;
    logic        retire;
    logic        wb_illegal;
    logic        rd_track;
    logic        rs1_hit;
    logic        rs2_hit;
    logic        full_block;
    logic        sat_block;
    logic        accept;
    logic [31:0] inc_vec;
    logic [31:0] dec_vec;

    assign wb_nz      = wb_valid && (wb_rd_addr != 5'd0);
    assign retire     = wb_nz && (cnt[wb_rd_addr] != '0);
    assign wb_illegal = wb_nz && (cnt[wb_rd_addr] == '0);

    // A source is still pending unless its last outstanding writer retires this cycle.
    assign rs1_hit = issue_uses_rs1 && (issue_rs1_addr != 5'd0) && (cnt[issue_rs1_addr] != '0) &&
                     !(wb_valid && (wb_rd_addr == issue_rs1_addr) && (cnt[issue_rs1_addr] == CNT_ONE));
    assign rs2_hit = issue_uses_rs2 && (issue_rs2_addr != 5'd0) && (cnt[issue_rs2_addr] != '0) &&
                     !(wb_valid && (wb_rd_addr == issue_rs2_addr) && (cnt[issue_rs2_addr] == CNT_ONE));

    assign rd_track   = issue_writes_rd && (issue_rd_addr != 5'd0);
    assign full_block = (inflight_count == MAX_IF) && !retire;
    assign sat_block  = (cnt[issue_rd_addr] == CNT_MAX) && !(retire && (wb_rd_addr == issue_rd_addr));

    assign issue_stall = issue_valid && (rs1_hit || rs2_hit || (rd_track && (full_block || sat_block)));
    assign accept      = issue_valid && !issue_stall && rd_track;

    assign inc_vec = accept ? (32'd1 << issue_rd_addr) : 32'd0;
    assign dec_vec = retire ? (32'd1 << wb_rd_addr)    : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                cnt[i] <= '0;
            end
            inflight_count <= '0;
            wb_err         <= 1'b0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    cnt[i] <= cnt[i] + CNT_ONE;
                end else if (dec_vec[i] && !inc_vec[i]) begin
                    cnt[i] <= cnt[i] - CNT_ONE;
                end
            end
            if (accept && !retire) begin
                inflight_count <= inflight_count + IW'(1);
            end else if (retire && !accept) begin
                inflight_count <= inflight_count - IW'(1);
            end
            if (wb_illegal) begin
                wb_err <= 1'b1;
            end
        end
    end

    always_comb begin
        pending_vec = '0;
        for (int i = 1; i < 32; i++) begin
            pending_vec[i] = (cnt[i] != '0);
        end
    end

    assign full = (inflight_count == MAX_IF);

    // Stall logic is meant to make these unreachable; they catch a broken stall path.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(accept && !(retire && wb_rd_addr == issue_rd_addr) && cnt[issue_rd_addr] == CNT_MAX))
                else $error("scoreboard counter overflow on rd %0d", issue_rd_addr);
            assert (!(retire && cnt[wb_rd_addr] == '0))
                else $error("scoreboard counter underflow on rd %0d", wb_rd_addr);
            assert (!(accept && !retire && inflight_count == MAX_IF))
                else $error("scoreboard inflight overflow");
            assert (!(retire && !accept && inflight_count == '0))
                else $error("scoreboard inflight underflow");
        end
    end

endmodule

// File: tb/tb_load_scoreboard.sv
// Directed bench for load_scoreboard with hand-computed expectations.
module tb_load_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rs1_addr;
    logic [4:0]  issue_rs2_addr;
    logic        issue_uses_rs1;
    logic        issue_uses_rs2;
    logic        issue_writes_rd;
    logic [4:0]  issue_rd_addr;
    logic        issue_stall;
    logic        wb_valid;
    logic [4:0]  wb_rd_addr;
    logic [31:0] pending_vec;
    logic [2:0]  inflight_count;
    logic        full;
    logic        wb_err;

    int checks = 0;
    int errors = 0;

    load_scoreboard #(.MAX_INFLIGHT(4), .CNT_W(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid     (issue_valid),
        .issue_rs1_addr  (issue_rs1_addr),
        .issue_rs2_addr  (issue_rs2_addr),
        .issue_uses_rs1  (issue_uses_rs1),
        .issue_uses_rs2  (issue_uses_rs2),
        .issue_writes_rd (issue_writes_rd),
        .issue_rd_addr   (issue_rd_addr),
        .issue_stall     (issue_stall),
        .wb_valid        (wb_valid),
        .wb_rd_addr      (wb_rd_addr),
        .pending_vec     (pending_vec),
        .inflight_count  (inflight_count),
        .full            (full),
        .wb_err          (wb_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and leave inputs idle, 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        issue_valid     = 1'b0;
        issue_uses_rs1  = 1'b0;
        issue_uses_rs2  = 1'b0;
        issue_writes_rd = 1'b0;
        wb_valid        = 1'b0;
    endtask

    task automatic issue_wr(input logic [4:0] rd);
        issue_valid = 1'b1; issue_writes_rd = 1'b1; issue_rd_addr = rd;
        issue_uses_rs1 = 1'b0; issue_uses_rs2 = 1'b0;
    endtask

    task automatic issue_rd1(input logic [4:0] rs);
        issue_valid = 1'b1; issue_writes_rd = 1'b0; issue_uses_rs1 = 1'b1; issue_rs1_addr = rs;
    endtask

    task automatic issue_rd2(input logic [4:0] rs);
        issue_valid = 1'b1; issue_writes_rd = 1'b0; issue_uses_rs2 = 1'b1; issue_rs2_addr = rs;
    endtask

    task automatic wb(input logic [4:0] rd);
        wb_valid = 1'b1; wb_rd_addr = rd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        issue_rs1_addr = '0; issue_rs2_addr = '0; issue_rd_addr = '0; wb_rd_addr = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_pending", pending_vec, 0);
        chk("rst_inflight", inflight_count, 0);
        chk("rst_full", full, 0);
        chk("rst_wb_err", wb_err, 0);
        chk("rst_stall", issue_stall, 0);

        // 1: single load, dependent reader, same-cycle writeback bypass
        issue_wr(5); #1;
        chk("t1_issue_stall", issue_stall, 0);
        tick();
        chk("t1_pending", pending_vec, 32'h20);
        chk("t1_inflight", inflight_count, 1);
        issue_rd1(5); #1;
        chk("t1_raw_stall", issue_stall, 1);
        issue_valid = 1'b0; #1;
        chk("t1_novalid_stall", issue_stall, 0);
        issue_valid = 1'b1; wb(5); #1;
        chk("t1_bypass_stall", issue_stall, 0);
        tick();
        chk("t1_pending_clr", pending_vec, 0);
        chk("t1_inflight_clr", inflight_count, 0);

        // 2: x0 is never tracked
        issue_wr(0); wb(0); #1;
        chk("t2_stall", issue_stall, 0);
        tick();
        chk("t2_pending", pending_vec, 0);
        chk("t2_inflight", inflight_count, 0);
        chk("t2_wb_err", wb_err, 0);

        // 3: fill table, fifth issue admitted only by a same-cycle retire
        for (int r = 1; r <= 4; r++) begin
            issue_wr(5'(r)); #1;
            chk("t3_fill_stall", issue_stall, 0);
            tick();
        end
        chk("t3_full", full, 1);
        chk("t3_inflight4", inflight_count, 4);
        issue_wr(6); #1;
        chk("t3_full_stall", issue_stall, 1);
        wb(2); #1;
        chk("t3_slot_free_stall", issue_stall, 0);
        tick();
        chk("t3_inflight", inflight_count, 4);
        chk("t3_pending", pending_vec, 32'h5A);
        wb(1); tick(); wb(3); tick(); wb(4); tick(); wb(6); tick();
        chk("t3_drain", inflight_count, 0);

        // 4: WAW on rd=7 up to counter saturation
        for (int k = 0; k < 3; k++) begin
            issue_wr(7); #1;
            chk("t4_waw_stall", issue_stall, 0);
            tick();
        end
        chk("t4_inflight3", inflight_count, 3);
        issue_wr(7); #1;
        chk("t4_sat_stall", issue_stall, 1);
        wb(7); #1;
        chk("t4_sat_wb_stall", issue_stall, 0);
        tick();
        chk("t4_sat_swap_inflight", inflight_count, 3);
        issue_rd2(7); #1;
        chk("t4_rs2_stall3", issue_stall, 1);
        wb(7); tick();
        issue_rd2(7); wb(7); #1;
        chk("t4_rs2_stall_cnt2_wb", issue_stall, 1);
        tick();
        chk("t4_pending7", pending_vec, 32'h80);
        issue_rd2(7); #1;
        chk("t4_rs2_stall1", issue_stall, 1);
        wb(7); #1;
        chk("t4_rs2_release", issue_stall, 0);
        tick();
        chk("t4_pending_clr", pending_vec, 0);
        chk("t4_inflight0", inflight_count, 0);

        // 5: simultaneous issue and retire of the same rd
        issue_wr(9); tick();
        issue_wr(9); wb(9); #1;
        chk("t5_stall", issue_stall, 0);
        tick();
        chk("t5_inflight", inflight_count, 1);
        chk("t5_pending", pending_vec, 32'h200);
        wb(9); tick();
        chk("t5_drain", inflight_count, 0);

        // 6: sticky wb_err, cleared only by reset
        wb(12); tick();
        chk("t6_wb_err", wb_err, 1);
        chk("t6_no_count", inflight_count, 0);
        issue_wr(3); tick(); wb(3); tick();
        chk("t6_wb_err_sticky", wb_err, 1);
        issue_wr(8); tick();
        chk("t6_pending8", pending_vec, 32'h100);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_rst_wb_err", wb_err, 0);
        chk("t6_rst_pending", pending_vec, 0);
        chk("t6_rst_inflight", inflight_count, 0);
        chk("t6_rst_full", full, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_scoreboard.md
Name: load_scoreboard

Overview:
- Register scoreboard for the RV32I pipeline. It tracks destination registers of long-latency operations (variable-latency loads, multi-cycle mul/div) from issue until writeback.
- It is the producer-side counterpart to the decode stage's single-cycle load-use stall. Writeback retires pending registers, and the block stalls issue of any instruction that reads a still-pending register.
- It sits between decode/issue and writeback. Its stall output is ORed into the existing pipeline stall controls.

Parameters:
- MAX_INFLIGHT, default 4: maximum long-latency operations outstanding at once.
- CNT_W, default 2: width of each per-register pending counter. It bounds in-flight writers to the same rd at 2^CNT_W-1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- issue_valid  input  1  a tracked instruction is presented for issue this cycle.
- issue_rs1_addr  input  5  source register 1.
- issue_rs2_addr  input  5  source register 2.
- issue_uses_rs1  input  1  instruction reads rs1.
- issue_uses_rs2  input  1  instruction reads rs2.
- issue_writes_rd  input  1  instruction is long-latency and writes rd, so rd must be tracked.
- issue_rd_addr  input  5  destination register.
- issue_stall  output  1  issue must hold; the instruction is not accepted this cycle.
- wb_valid  input  1  a long-latency result is written back this cycle.
- wb_rd_addr  input  5  register being written back.
- pending_vec  output  32  bit i is set when register i has a nonzero pending count.
- inflight_count  output  $clog2(MAX_INFLIGHT+1)  tracked operations outstanding.
- full  output  1  inflight_count == MAX_INFLIGHT.
- wb_err  output  1  sticky: a writeback arrived for a non-pending register.

Behaviour:
- Reset (rst=1 at a clock edge): all per-register counters = 0, inflight_count = 0, wb_err = 0. Therefore pending_vec = 0, full = 0 and issue_stall = 0 (given issue_valid=0) in the cycle after reset. Reset mid-operation discards all tracking; writebacks still in flight after reset are the flushing logic's responsibility. They set wb_err if they arrive.
- x0: never pending. Issue with rd=0 is not tracked and does not count toward inflight. wb with rd=0 is ignored and does not set wb_err.
- Effective pending (combinational) for register r:
  - cnt[r] != 0, and
  - NOT (wb_valid && wb_rd_addr==r && cnt[r]==1).
  - This is the same-cycle writeback bypass; the regfile is write-through.
- issue_stall = issue_valid AND (any of):
  - issue_uses_rs1 && eff_pending(rs1), rs1 != 0
  - issue_uses_rs2 && eff_pending(rs2), rs2 != 0
  - issue_writes_rd && rd != 0 && inflight_count == MAX_INFLIGHT, unless wb_valid with a legal retire this cycle (slot frees same cycle)
  - issue_writes_rd && rd != 0 && cnt[rd] == 2^CNT_W-1, unless a legal wb to rd this cycle
- issue_stall must be 0 when issue_valid = 0.
- Accepted issue = issue_valid && !issue_stall && issue_writes_rd && rd != 0. Effect at the next edge: cnt[rd] += 1, inflight += 1.
- Legal retire = wb_valid && wb_rd_addr != 0 && cnt[wb_rd_addr] != 0. Effect at the next edge: cnt[wb_rd] -= 1, inflight -= 1.
- Illegal wb (wb_valid, rd != 0, cnt == 0): no counter change; wb_err is set at the next edge and held until rst.
- Simultaneous accepted issue and legal retire:
  - Same rd: cnt[rd] is unchanged and inflight is unchanged.
  - Different rd: each counter is updated independently and inflight is unchanged.
- Counters never wrap; the stall conditions guarantee no overflow. An assertion must flag any attempted overflow or underflow.
- Latency:
  - Issue to pending_vec visible: 1 cycle.
  - Writeback to stall release: 0 cycles (bypass).
  - pending_vec, inflight_count and full are registered-state views; they do not include the bypass.

Test Plan:
1. Reset, then issue a load with rd=5 → next cycle pending_vec=32'h20, inflight=1. An issue reading rs1=5 gets issue_stall=1. wb rd=5 in the same cycle as that issue → issue_stall=0; next cycle pending_vec=0, inflight=0.
2. Issue rd=0 long op; wb rd=0 → pending_vec stays 0, inflight stays 0, wb_err stays 0.
3. Fill 4 ops (rd=1,2,3,4), then a 5th issue rd=6 → full=1, issue_stall=1. wb rd=2 in the same cycle → 5th accepted; next cycle inflight=4, pending_vec=32'h5A.
4. WAW on rd=7: three issues accepted (cnt=3). Fourth stalls. Two wbs → pending_vec[7] still 1. Third wb → bit 7 clears. An rs2=7 reader stalls until the third wb cycle.
5. Simultaneous issue rd=9 and wb rd=9 with cnt[9]=1 → cnt[9] stays 1, inflight unchanged.
6. wb rd=12 with cnt=0 → wb_err=1 next cycle and stays 1 across later legal traffic. Assert rst → wb_err=0, pending_vec=0, inflight=0.
